button_event_capture: RTL and testbench
=======================================

BUTTON_EVENT_CAPTURE -- requirements
Module: button_event_capture

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of push-buttons captured (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a level (10 ms at 50 MHz).
REQ-003 SHALL have port clk_clk, input, 1, the single system clock.
REQ-004 SHALL have port reset_reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port keys_n, input, NUM_KEYS, raw board buttons, active-low, asynchronous to clk_clk.
REQ-006 SHALL have port ack_word, input, 32, host-written PIO output word carrying the clear mask and acknowledge toggle.
REQ-007 SHALL have port status_word, output, 32, word presented to the host-read PIO input.

Function
REQ-008 SHALL synchronize each keys_n bit through two flops, then invert it so that 1 = pressed.
REQ-009 SHALL hold a per-key debounced level and counter; the counter SHALL clear whenever the synchronized level equals the debounced level, and increment otherwise.
REQ-010 SHALL update the debounced level when the counter reaches DEBOUNCE_CYCLES-1, clearing the counter in the same cycle; a bounce before then SHALL restart the count from 0.
REQ-011 SHALL raise a one-cycle internal press event on a debounced 0->1 transition; release events SHALL be ignored.
REQ-012 SHALL set sticky bit n on a press event of key n.
REQ-013 SHALL set the overflow flag on a press event for a key whose sticky bit is already 1; the flag SHALL be cleared only by reset.
REQ-014 SHALL synchronize ack_word[31] through two flops; a change relative to the last accepted toggle SHALL be an acknowledge.
REQ-015 On acknowledge, SHALL clear sticky bits selected by ack_word[NUM_KEYS-1:0], sampled in the same cycle the toggle change is detected, and SHALL latch the new toggle value.
REQ-016 When a set and a clear of the same sticky bit coincide, the set SHALL win.
REQ-017 status_word layout SHALL be: [7:0] debounced levels, zero-extended; [15:8] sticky bits, zero-extended; [23:16] press counter; [24] overflow; [30:25] 0; [31] last accepted toggle.
REQ-018 status_word SHALL be fully registered, reflecting state one cycle after it changes.
REQ-019 Total latency from a clean keys_n edge to the sticky bit appearing on status_word SHALL be 2 sync + DEBOUNCE_CYCLES + 2 cycles.

Reset
REQ-020 Assertion of reset_reset_n SHALL asynchronously clear all sync flops, counters, debounced levels, sticky bits, overflow, press counter, toggle and status_word to 0.
REQ-021 Reset mid-debounce SHALL discard the partial count; no press event SHALL be produced on deassertion while keys are released.

Configuration
REQ-022 Macro BEC_PRESS_COUNT_EN SHALL select the press counter.
REQ-023 With BEC_PRESS_COUNT_EN defined: an 8-bit counter SHALL increment once per press event on any key and wrap 255->0. Simultaneous presses on k keys SHALL add k, modulo 256.
REQ-024 Without BEC_PRESS_COUNT_EN: status_word[23:16] SHALL read 0 and no counter logic SHALL be synthesized.

Structure
REQ-025 Package bec_pkg SHALL hold the status_word bit-position constants, the ACK_TOGGLE_BIT constant (31) and the default DEBOUNCE_CYCLES.
REQ-026 Per-key debounce SHALL be sub-module bec_debounce, instantiated NUM_KEYS times by generate.
REQ-027 The bec_debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES).

Verification (DEBOUNCE_CYCLES=4, NUM_KEYS=4)
REQ-028 Reset, keys_n=4'hF, ack_word=0 -> status_word=32'h0 throughout.
REQ-029 keys_n[1] low, held 10 cycles -> status_word[1]=1 and [9]=1 exactly 8 cycles after the edge; [23:16]=1.
REQ-030 keys_n[0] toggling every 2 cycles for 20 cycles -> status_word stays 0.
REQ-031 Sticky 4'b0011 set; host writes ack_word=32'h8000_0001 -> sticky becomes 4'b0010 and [31]=1; repeating the same word -> no change.
REQ-032 Key 2 is pressed twice without an ack -> status_word[24]=1; a press landing in the same cycle as an ack clearing bit 2 -> bit 2 stays 1.
REQ-033 With BEC_PRESS_COUNT_EN, 257 presses -> [23:16]=1; without the macro -> [23:16]=0.

Source files
------------

// File: rtl/bec_pkg.sv
// Shared constants for the button event capture block: status_word field
// positions, the acknowledge toggle bit and the default debounce length.
package bec_pkg;

    localparam int ST_LEVEL_LSB            = 0;
    localparam int ST_STICKY_LSB           = 8;
    localparam int ST_COUNT_LSB            = 16;
    localparam int ST_OVF_BIT              = 24;
    localparam int ACK_TOGGLE_BIT          = 31;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int MAX_KEYS                = 8;

    function automatic logic [7:0] popcount8(input logic [7:0] v);
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/bec_debounce.sv
// Single-key debouncer: accepts a new level only after it has differed from
// the held level for DEBOUNCE_CYCLES consecutive cycles.
module bec_debounce
    import bec_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic level_i,
    output logic level_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // Next-state: any return to the held level restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (level_i == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = level_i;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/button_event_capture.sv
// Push-button capture for a host PIO pair: debounced levels, sticky press
// bits with toggle-acknowledged clear, overflow flag; press counter under BEC_PRESS_COUNT_EN.
module button_event_capture
    import bec_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] keys_n,
    input  logic [31:0]         ack_word,
    output logic [31:0]         status_word
);

    logic [NUM_KEYS-1:0] key_meta_q;
    logic [NUM_KEYS-1:0] key_sync_q;
    logic [NUM_KEYS-1:0] deb_level_s;
    logic [NUM_KEYS-1:0] level_q;
    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] clr_mask_s;
    logic [NUM_KEYS-1:0] sticky_q;
    logic [NUM_KEYS-1:0] sticky_d;
    logic                ack_meta_q;
    logic                ack_sync_q;
    logic                ack_s;
    logic                tog_q;
    logic                tog_d;
    logic                ovf_q;
    logic                ovf_d;
    logic [31:0]         status_d;
    logic                unused_ack_s;

    assign unused_ack_s = ^ack_word[ACK_TOGGLE_BIT-1:NUM_KEYS];

    // Input synchronizers; keys are inverted ahead of the flops so a cleared
    // synchronizer reads "released" and reset never fakes a press.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_meta_q <= '0;
            key_sync_q <= '0;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            key_meta_q <= ~keys_n;
            key_sync_q <= key_meta_q;
            ack_meta_q <= ack_word[ACK_TOGGLE_BIT];
            ack_sync_q <= ack_meta_q;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
        bec_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i   (clk_clk),
            .rst_n_i (reset_reset_n),
            .level_i (key_sync_q[g]),
            .level_o (deb_level_s[g])
        );
    end

    // Event and sticky next-state; a coincident press overrides the clear.
    always_comb begin
        press_s = deb_level_s & ~level_q;
        ack_s   = ack_sync_q ^ tog_q;
        if (ack_s) begin
            clr_mask_s = ack_word[NUM_KEYS-1:0];
            tog_d      = ack_sync_q;
        end else begin
            clr_mask_s = '0;
            tog_d      = tog_q;
        end
        sticky_d = (sticky_q & ~clr_mask_s) | press_s;
        ovf_d    = ovf_q | (|(press_s & sticky_q));
    end

    // Event state; level_q also delays the levels so they line up with sticky.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            level_q  <= '0;
            sticky_q <= '0;
            ovf_q    <= 1'b0;
            tog_q    <= 1'b0;
        end else begin
            level_q  <= deb_level_s;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
            tog_q    <= tog_d;
        end
    end

`ifdef BEC_PRESS_COUNT_EN
    logic [7:0] press_cnt_q;
    logic [7:0] press_cnt_d;

    // Simultaneous presses add their count in one step, wrapping at 256.
    always_comb begin
        press_cnt_d = press_cnt_q + popcount8(8'(press_s));
    end

    // Press counter register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            press_cnt_q <= 8'd0;
        end else begin
            press_cnt_q <= press_cnt_d;
        end
    end
`endif

    // Host-visible word assembly.
    always_comb begin
        status_d                              = 32'd0;
        status_d[ST_LEVEL_LSB +: NUM_KEYS]    = level_q;
        status_d[ST_STICKY_LSB +: NUM_KEYS]   = sticky_q;
`ifdef BEC_PRESS_COUNT_EN
        status_d[ST_COUNT_LSB +: 8]           = press_cnt_q;
`else
        status_d[ST_COUNT_LSB +: 8]           = 8'd0;
`endif
        status_d[ST_OVF_BIT]                  = ovf_q;
        status_d[ACK_TOGGLE_BIT]              = tog_q;
    end

    // Registered status output.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            status_word <= 32'd0;
        end else begin
            status_word <= status_d;
        end
    end

endmodule

// File: tb/tb_button_event_capture.sv
// Scoreboard bench for button_event_capture with DEBOUNCE_CYCLES=4, NUM_KEYS=4.
module tb_button_event_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  keys_n;
    logic [31:0] ack_word;
    logic [31:0] status_word;

    typedef struct {
        int          cyc;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    button_event_capture #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .keys_n        (keys_n),
        .ack_word      (ack_word),
        .status_word   (status_word)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] cntf(input int n);
`ifdef BEC_PRESS_COUNT_EN
        return 32'(n % 256) << 16;
`else
        return 32'd0;
`endif
    endfunction

    // Queue an expected status_word for cycle cyc+dly, kept in cycle order.
    task automatic expect_at(input int dly, input logic [31:0] exp, input string name);
        exp_t e;
        int   idx;
        e.cyc  = cyc + dly;
        e.exp  = exp;
        e.name = name;
        idx    = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > e.cyc) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops entries due this cycle and compares away from the clock edge.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc || status_word !== e.exp) begin
                n_fail++;
                $display("FAIL %s: cycle %0d status_word=%h, required %h at cycle %0d",
                         e.name, cyc, status_word, e.exp, e.cyc);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        keys_n   = 4'hF;
        ack_word = 32'h0;
        tick(1);
        n_checks++;
        if (status_word !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_direct: status_word=%h, required 00000000", status_word);
        end
        for (int i = 0; i < 4; i++) expect_at(i, 32'h0, "reset_hold");
        tick(4);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) expect_at(i, 32'h0, "idle_zero");
        tick(10);

        // Bouncing key 0 never lasts long enough to be accepted.
        for (int i = 0; i < 10; i++) begin
            keys_n[0] = ~keys_n[0];
            expect_at(0, 32'h0, "bounce");
            expect_at(1, 32'h0, "bounce");
            tick(2);
        end
        for (int i = 0; i < 10; i++) expect_at(i, 32'h0, "bounce_settle");
        tick(10);

        // Reset in the middle of a debounce discards it.
        keys_n[3] = 1'b0;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        keys_n[3] = 1'b1;
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) expect_at(i, 32'h0, "reset_mid_debounce");
        tick(12);

        // Key 1 press: visible exactly 8 cycles after the edge.
        keys_n = 4'b1101;
        expect_at(7, 32'h0, "press1_early");
        expect_at(8, 32'h0000_0202 | cntf(1), "press1_latency");
        tick(10);
        keys_n = 4'hF;
        expect_at(10, 32'h0000_0200 | cntf(1), "press1_release");
        tick(10);

        keys_n = 4'b1110;
        tick(10);
        keys_n = 4'hF;
        expect_at(10, 32'h0000_0300 | cntf(2), "press0_sticky");
        tick(10);

        // Toggle acknowledge clearing bit 0.
        ack_word = 32'h8000_0001;
        expect_at(3, 32'h0000_0300 | cntf(2), "ack_before");
        expect_at(4, 32'h8000_0200 | cntf(2), "ack_clear");
        tick(6);
        ack_word = 32'h8000_0001;
        expect_at(8, 32'h8000_0200 | cntf(2), "ack_repeat");
        tick(10);

        // Key 2 twice without ack sets overflow.
        keys_n = 4'b1011;
        tick(10);
        keys_n = 4'hF;
        expect_at(10, 32'h8000_0600 | cntf(3), "press2_first");
        tick(10);
        keys_n = 4'b1011;
        tick(10);
        keys_n = 4'hF;
        expect_at(10, 32'h8100_0600 | cntf(4), "overflow");
        tick(10);

        // Press event and ack clear of bit 2 land in the same cycle.
        keys_n = 4'b1011;
        tick(4);
        ack_word = 32'h0000_0004;
        expect_at(3, 32'h8100_0600 | cntf(4), "coincide_before");
        expect_at(4, 32'h0100_0604 | cntf(5), "coincide_set_wins");
        tick(6);
        keys_n = 4'hF;
        expect_at(10, 32'h0100_0600 | cntf(5), "coincide_release");
        tick(10);

        // All four keys at once add four presses.
        keys_n = 4'h0;
        expect_at(8, 32'h0100_0F0F | cntf(9), "all_keys_press");
        tick(10);
        keys_n = 4'hF;
        expect_at(10, 32'h0100_0F00 | cntf(9), "all_keys_release");
        tick(10);

        // 248 more presses brings the total to 257: counter wraps to 1.
        for (int i = 0; i < 248; i++) begin
            keys_n = 4'b1110;
            tick(6);
            keys_n = 4'hF;
            tick(6);
        end
        tick(12);
        expect_at(0, 32'h0100_0F00 | cntf(257), "count_wrap");
        tick(2);
        n_checks++;
        if (status_word !== (32'h0100_0F00 | cntf(257))) begin
            n_fail++;
            $display("FAIL count_wrap_direct: status_word=%h, required %h",
                     status_word, 32'h0100_0F00 | cntf(257));
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked, required %h at cycle %0d", e.name, e.exp, e.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d, failures %0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
